cu_multiword: RTL and testbench
===============================

// Module: cu_multiword
// PURPOSE
//  Parametrised control unit for multi-limb (WORDS x datapath width) operands.
//  An internal limb counter replaces the external repeat-stop input; every ALU op runs once per limb.
//  Carry is chained across limbs. A zero flag accumulates across limbs and drives the new JZ branch.
//  HLT parks the core until a run pulse restarts it. Drives the PC, IR, RAM write and ALU control, as the single-word CU does.
// PARAMETERS
//  WORDS     4  limbs per operand; legal range 1..2^LIMB_W
//  LIMB_W    2  width of the limb index
//  ALU_OP_W  3  width of alu_op; codes are the `ALU_* macros from alu_ops.v
// PORTS
//  clk          in   1         system clock; state updates on the falling edge
//  reset_n      in   1         asynchronous, active-low reset
//  run          in   1         restart pulse, sampled only in STOP
//  opcode_old   in   4         opcode of the executing instruction (IR)
//  opcode_new   in   4         opcode of the next instruction (memory out)
//  carry        in   1         datapath carry flag
//  alu_zero     in   1         ALU result == 0 for the current limb
//  is_imm       out  1         select immediate operand (ADDI/SUBI)
//  carry_chain  out  1         ALU takes carry/borrow-in from the previous limb
//  limb_idx     out  LIMB_W    limb being processed; 0 = least significant
//  alu_op       out  ALU_OP_W  ALU function
//  pc_enable    out  1         increment PC
//  pc_load      out  1         load PC with the branch target
//  pc_reset     out  1         clear PC
//  flags_reset  out  1         clear datapath flags
//  ram_we       out  1         write the result limb back
//  ir_enable    out  1         load IR with the next instruction
//  halted       out  1         core in STOP
// BEHAVIOUR
//  Opcodes: AND 0000, NOT 0001, OR 0010, XOR 0011, SET 0100, JMP 0101, ADD 0110,
//   ADDI 1000, SUB 1001, SUBI 1010, JC 1011, JZ 1100, HLT 1111. Any other code decodes as a NOP ALU op.
//  States: INIT, ALU_SRC, ALU_SRC_C, ALU_IMM, ALU_IMM_C, BR_TAKEN, BR_NOT, STOP.
//  Reset (async, reset_n=0, any state): state=INIT, limb_idx=0, zero_acc=1.
//   Outputs then: pc_reset=1, flags_reset=1, ir_enable=1; all other 1-bit outputs 0.
//  DECODE(opcode_new) gives the next state:
//   HLT -> STOP; JMP -> BR_TAKEN; JC -> carry ? BR_TAKEN : BR_NOT;
//   JZ -> zero_acc ? BR_TAKEN : BR_NOT; ADDI/SUBI -> ALU_IMM; else -> ALU_SRC.
//  INIT, BR_TAKEN, BR_NOT: one cycle each, then DECODE.
//  ALU_SRC/ALU_IMM (limb 0):
//   WORDS==1 -> DECODE next.
//   WORDS>1  -> *_C next, limb_idx <= 1.
//  ALU_*_C: limb_idx increments each cycle. At limb_idx==WORDS-1 it goes to DECODE and limb_idx <= 0.
//  ALU op latency = WORDS cycles. Branches and INIT take 1 cycle.
//  STOP: holds, halted=1. If run=1 at a falling edge -> DECODE.
//   Pulses on run outside STOP are ignored.
//  Output decode (Moore, from state and limb_idx):
//   is_imm = ALU_IMM | ALU_IMM_C
//   carry_chain = *_C state and opcode_old in {ADD, ADDI, SUB, SUBI}
//   ram_we = any ALU state
//   last = (limb_idx==WORDS-1)
//   pc_enable = (ALU state & last) | BR_NOT
//   pc_load = BR_TAKEN
//   ir_enable = INIT | BR_* | STOP | (ALU state & last)
//  alu_op from opcode_old in every state:
//   AND/NOT/OR/XOR -> `ALU_AND/`ALU_NOT/`ALU_OR/`ALU_XOR
//   ADD/ADDI -> `ALU_ADD; SUB/SUBI -> `ALU_SUB
//   others -> `ALU_AND. Fully assigned, no latches.
//   carry_chain alone selects carry-in use.
//  zero_acc, updated on the falling edge in ALU states:
//   limb 0 -> zero_acc <= alu_zero
//   else   -> zero_acc <= zero_acc & alu_zero
//   Holds in other states. JZ therefore tests the whole multi-limb result.
//  Reset mid-operation: limb counter and zero_acc clear immediately. No partial op resumes.
// TESTING
//  1. reset_n low then high, opcode_new=ADD, WORDS=4 -> INIT 1 cycle (pc_reset=1), then 4 ALU cycles.
//     limb_idx 0,1,2,3; carry_chain 0,1,1,1; ram_we=1 all 4; pc_enable only on limb 3.
//  2. ADDI, then alu_zero=1,1,1,1 and opcode_new=JZ -> is_imm=1 for 4 cycles, then BR_TAKEN, pc_load=1.
//     Repeat with alu_zero=1,0,1,1 -> BR_NOT, pc_enable=1.
//  3. opcode_new=JC, carry=1 -> BR_TAKEN. With carry=0 -> BR_NOT.
//     XOR op -> carry_chain=0 on all limbs.
//  4. HLT -> halted=1 held 10 cycles regardless of opcode_new. run=1 for 1 cycle with opcode_new=SUB -> ALU_SRC.
//  5. reset_n low during limb 2 of SUB -> immediately INIT, limb_idx=0, pc_reset=1, ram_we=0.
//  6. WORDS=1 build: ADD -> single cycle, pc_enable=1, carry_chain=0. ALU_*_C never entered.

Source files
------------

// File: rtl/cu_multiword.sv
// cu_multiword: control unit sequencing ALU ops over WORDS limbs,
// with a carry chain, a zero accumulator for JZ, and HLT/run parking.
//
// Ports:
//   clk          system clock; state moves on the falling edge
//   reset_n      asynchronous active-low reset
//   run          restart pulse, honoured only while halted
//   opcode_old   opcode held in IR (instruction executing)
//   opcode_new   opcode at memory output (next instruction)
//   carry        datapath carry flag, used by JC
//   alu_zero     ALU result of the current limb is zero
//   is_imm       select the immediate operand
//   carry_chain  ALU uses carry/borrow from the previous limb
//   limb_idx     limb being processed, 0 = least significant
//   alu_op       ALU function code
//   pc_enable    increment PC
//   pc_load      load PC with branch target
//   pc_reset     clear PC
//   flags_reset  clear datapath flags
//   ram_we       write result limb back
//   ir_enable    load IR from opcode_new
//   halted       core is parked in STOP
module cu_multiword #(
  parameter int WORDS    = 4,
  parameter int LIMB_W   = 2,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [3:0]          opcode_old,
  input  logic [3:0]          opcode_new,
  input  logic                carry,
  input  logic                alu_zero,
  output logic                is_imm,
  output logic                carry_chain,
  output logic [LIMB_W-1:0]   limb_idx,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                pc_enable,
  output logic                pc_load,
  output logic                pc_reset,
  output logic                flags_reset,
  output logic                ram_we,
  output logic                ir_enable,
  output logic                halted
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_NOT  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_JMP  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SUBI = 4'b1010;
  localparam logic [3:0] OP_JC   = 4'b1011;
  localparam logic [3:0] OP_JZ   = 4'b1100;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_NOT = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(5);

  localparam logic [2:0] S_INIT      = 3'd0;
  localparam logic [2:0] S_ALU_SRC   = 3'd1;
  localparam logic [2:0] S_ALU_SRC_C = 3'd2;
  localparam logic [2:0] S_ALU_IMM   = 3'd3;
  localparam logic [2:0] S_ALU_IMM_C = 3'd4;
  localparam logic [2:0] S_BR_TAKEN  = 3'd5;
  localparam logic [2:0] S_BR_NOT    = 3'd6;
  localparam logic [2:0] S_STOP      = 3'd7;

  localparam logic [LIMB_W-1:0] LIMB_LAST = LIMB_W'(WORDS - 1);
  localparam logic [LIMB_W-1:0] LIMB_ONE  = LIMB_W'(1);

  logic [2:0]        state_q, state_d;
  logic [LIMB_W-1:0] limb_q, limb_d;
  logic              zero_acc_q, zero_acc_d;
  logic [2:0]        dec_state;
  logic              alu_st;
  logic              chain_st;
  logic              last;
  logic              arith;

  assign alu_st = (state_q == S_ALU_SRC)   |
                  (state_q == S_ALU_SRC_C) |
                  (state_q == S_ALU_IMM)   |
                  (state_q == S_ALU_IMM_C);

  assign chain_st = (state_q == S_ALU_SRC_C) |
                    (state_q == S_ALU_IMM_C);

  assign last = (limb_q == LIMB_LAST);

  // Accumulate over limbs; limb 0 restarts the accumulation.
  always_comb begin
    zero_acc_d = zero_acc_q;
    if (alu_st) begin
      if (limb_q == '0) zero_acc_d = alu_zero;
      else              zero_acc_d = zero_acc_q & alu_zero;
    end
  end

  // JZ looks at zero_acc_d so the final limb's result is included
  // when the branch is decoded straight after the last ALU cycle.
  always_comb begin
    case (opcode_new)
      OP_HLT:  dec_state = S_STOP;
      OP_JMP:  dec_state = S_BR_TAKEN;
      OP_JC:   dec_state = carry ? S_BR_TAKEN : S_BR_NOT;
      OP_JZ:   dec_state = zero_acc_d ? S_BR_TAKEN : S_BR_NOT;
      OP_ADDI: dec_state = S_ALU_IMM;
      OP_SUBI: dec_state = S_ALU_IMM;
      default: dec_state = S_ALU_SRC;
    endcase
  end

  always_comb begin
    state_d = state_q;
    limb_d  = limb_q;
    case (state_q)
      S_INIT, S_BR_TAKEN, S_BR_NOT: begin
        state_d = dec_state;
        limb_d  = '0;
      end
      S_ALU_SRC, S_ALU_IMM: begin
        if (WORDS == 1) begin
          state_d = dec_state;
          limb_d  = '0;
        end else begin
          state_d = (state_q == S_ALU_SRC) ? S_ALU_SRC_C : S_ALU_IMM_C;
          limb_d  = LIMB_ONE;
        end
      end
      S_ALU_SRC_C, S_ALU_IMM_C: begin
        if (last) begin
          state_d = dec_state;
          limb_d  = '0;
        end else begin
          limb_d = limb_q + LIMB_ONE;
        end
      end
      S_STOP: begin
        if (run) state_d = dec_state;
      end
      default: begin
        state_d = S_INIT;
        limb_d  = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      limb_q     <= '0;
      zero_acc_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      limb_q     <= limb_d;
      zero_acc_q <= zero_acc_d;
    end
  end

  always_comb begin
    case (opcode_old)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: arith = 1'b1;
      default:                          arith = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode_old)
      OP_AND:  alu_op = ALU_AND;
      OP_NOT:  alu_op = ALU_NOT;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      OP_ADD:  alu_op = ALU_ADD;
      OP_ADDI: alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_SUBI: alu_op = ALU_SUB;
      default: alu_op = ALU_AND;
    endcase
  end

  assign limb_idx    = limb_q;
  assign is_imm      = (state_q == S_ALU_IMM) |
                       (state_q == S_ALU_IMM_C);
  assign carry_chain = chain_st & arith;
  assign ram_we      = alu_st;
  assign pc_enable   = (alu_st & last) | (state_q == S_BR_NOT);
  assign pc_load     = (state_q == S_BR_TAKEN);
  assign pc_reset    = (state_q == S_INIT);
  assign flags_reset = (state_q == S_INIT);
  assign halted      = (state_q == S_STOP);
  assign ir_enable   = (state_q == S_INIT)     |
                       (state_q == S_BR_TAKEN) |
                       (state_q == S_BR_NOT)   |
                       (state_q == S_STOP)     |
                       (alu_st & last);

endmodule

// File: tb/tb_cu_multiword.sv
// tb_cu_multiword: vector table plus scoreboard queue for the
// multi-limb control unit, with a WORDS=1 instance alongside.
module tb_cu_multiword;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, run, carry, alu_zero;
  logic [3:0] opcode_new, opcode_old, opcode_old1;

  logic       is_imm, carry_chain, pc_enable, pc_load;
  logic       pc_reset, flags_reset, ram_we, ir_enable, halted;
  logic [1:0] limb_idx;
  logic [2:0] alu_op;

  logic       w1_is_imm, w1_carry_chain, w1_pc_enable, w1_pc_load;
  logic       w1_pc_reset, w1_flags_reset, w1_ram_we;
  logic       w1_ir_enable, w1_halted;
  logic [0:0] w1_limb_idx;
  logic [2:0] w1_alu_op;

  cu_multiword #(.WORDS(4), .LIMB_W(2), .ALU_OP_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .opcode_old(opcode_old), .opcode_new(opcode_new),
    .carry(carry), .alu_zero(alu_zero),
    .is_imm(is_imm), .carry_chain(carry_chain),
    .limb_idx(limb_idx), .alu_op(alu_op),
    .pc_enable(pc_enable), .pc_load(pc_load),
    .pc_reset(pc_reset), .flags_reset(flags_reset),
    .ram_we(ram_we), .ir_enable(ir_enable), .halted(halted)
  );

  cu_multiword #(.WORDS(1), .LIMB_W(1), .ALU_OP_W(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .run(run),
    .opcode_old(opcode_old1), .opcode_new(opcode_new),
    .carry(carry), .alu_zero(alu_zero),
    .is_imm(w1_is_imm), .carry_chain(w1_carry_chain),
    .limb_idx(w1_limb_idx), .alu_op(w1_alu_op),
    .pc_enable(w1_pc_enable), .pc_load(w1_pc_load),
    .pc_reset(w1_pc_reset), .flags_reset(w1_flags_reset),
    .ram_we(w1_ram_we), .ir_enable(w1_ir_enable),
    .halted(w1_halted)
  );

  localparam logic [3:0] AND_ = 4'b0000, XOR_ = 4'b0011;
  localparam logic [3:0] JMP_ = 4'b0101, ADD_ = 4'b0110;
  localparam logic [3:0] ADDI_ = 4'b1000, SUB_ = 4'b1001;
  localparam logic [3:0] JC_ = 4'b1011, JZ_ = 4'b1100;
  localparam logic [3:0] HLT_ = 4'b1111;

  localparam logic [2:0] A_AND = 3'd0, A_XOR = 3'd3;
  localparam logic [2:0] A_ADD = 3'd4, A_SUB = 3'd5;

  // flag bits: cc imm we pce pcl pcr fr ire hlt
  localparam logic [8:0] CC  = 9'b1_0000_0000;
  localparam logic [8:0] IM  = 9'b0_1000_0000;
  localparam logic [8:0] WE  = 9'b0_0100_0000;
  localparam logic [8:0] LST = 9'b0_0010_0010;
  localparam logic [8:0] BT  = 9'b0_0001_0010;
  localparam logic [8:0] BN  = 9'b0_0010_0010;
  localparam logic [8:0] IN  = 9'b0_0000_1110;
  localparam logic [8:0] ST  = 9'b0_0000_0011;

  typedef struct packed {
    logic [1:0] lim;
    logic [8:0] f;
    logic [2:0] aop;
  } out_t;

  typedef struct {
    logic       rn;
    logic [3:0] onew;
    logic       c;
    logic       z;
    logic       r;
    out_t       e;
  } vec_t;

  out_t q0[$];
  out_t q1[$];
  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;
  logic ir_last, ir1_last;

  function automatic out_t ox(input logic [1:0] l,
                              input logic [8:0] f,
                              input logic [2:0] a);
    out_t o;
    o.lim = l;
    o.f   = f;
    o.aop = a;
    return o;
  endfunction

  function automatic vec_t mk(input logic rn, input logic [3:0] on,
                              input logic c, input logic z,
                              input logic r, input logic [1:0] l,
                              input logic [8:0] f,
                              input logic [2:0] a);
    vec_t v;
    v.rn = rn;
    v.onew = on;
    v.c = c;
    v.z = z;
    v.r = r;
    v.e = ox(l, f, a);
    return v;
  endfunction

  function automatic out_t act0();
    out_t o;
    o.lim = limb_idx;
    o.f = {carry_chain, is_imm, ram_we, pc_enable, pc_load,
           pc_reset, flags_reset, ir_enable, halted};
    o.aop = alu_op;
    return o;
  endfunction

  function automatic out_t act1();
    out_t o;
    o.lim = {1'b0, w1_limb_idx};
    o.f = {w1_carry_chain, w1_is_imm, w1_ram_we, w1_pc_enable,
           w1_pc_load, w1_pc_reset, w1_flags_reset,
           w1_ir_enable, w1_halted};
    o.aop = w1_alu_op;
    return o;
  endfunction

  task automatic cmp(input string nm, input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got lim=%0d flags=%b aop=%0d, want lim=%0d flags=%b aop=%0d",
               nm, a.lim, a.f, a.aop, e.lim, e.f, e.aop);
    end
  endtask

  // Drive one cycle, let the falling edge act, model the IR
  // load, then pop the scoreboard and compare.
  task automatic apply(input vec_t v, input string nm,
                       input bit chk1, input out_t e1);
    out_t e;
    reset_n    = v.rn;
    opcode_new = v.onew;
    carry      = v.c;
    alu_zero   = v.z;
    run        = v.r;
    q0.push_back(v.e);
    if (chk1) q1.push_back(e1);
    @(negedge clk);
    if (ir_last)  opcode_old  = v.onew;
    if (ir1_last) opcode_old1 = v.onew;
    #1;
    e = q0.pop_front();
    cmp(nm, act0(), e);
    if (chk1) begin
      e = q1.pop_front();
      cmp({nm, "_w1"}, act1(), e);
    end
    ir_last  = ir_enable;
    ir1_last = w1_ir_enable;
  endtask

  initial begin
    out_t e;
    out_t none;
    none = ox(0, 0, 0);
    reset_n = 1'b0;
    run = 1'b0;
    carry = 1'b0;
    alu_zero = 1'b0;
    opcode_new = AND_;
    opcode_old = AND_;
    opcode_old1 = AND_;
    ir_last = 1'b0;
    ir1_last = 1'b0;

    tbl.push_back(mk(0, ADD_,  0, 0, 0, 0, IN, A_AND));
    tbl.push_back(mk(1, ADD_,  0, 0, 0, 0, WE, A_ADD));
    tbl.push_back(mk(1, ADD_,  0, 0, 0, 1, CC|WE, A_ADD));
    tbl.push_back(mk(1, ADD_,  0, 0, 0, 2, CC|WE, A_ADD));
    tbl.push_back(mk(1, ADDI_, 0, 0, 0, 3, CC|WE|LST, A_ADD));
    tbl.push_back(mk(1, ADDI_, 0, 0, 0, 0, IM|WE, A_ADD));
    tbl.push_back(mk(1, ADDI_, 0, 1, 0, 1, CC|IM|WE, A_ADD));
    tbl.push_back(mk(1, ADDI_, 0, 1, 0, 2, CC|IM|WE, A_ADD));
    tbl.push_back(mk(1, JZ_,   0, 1, 0, 3, CC|IM|WE|LST, A_ADD));
    tbl.push_back(mk(1, JZ_,   0, 1, 0, 0, BT, A_AND));
    tbl.push_back(mk(1, ADDI_, 0, 0, 0, 0, IM|WE, A_ADD));
    tbl.push_back(mk(1, ADDI_, 0, 1, 0, 1, CC|IM|WE, A_ADD));
    tbl.push_back(mk(1, ADDI_, 0, 0, 0, 2, CC|IM|WE, A_ADD));
    tbl.push_back(mk(1, JZ_,   0, 1, 0, 3, CC|IM|WE|LST, A_ADD));
    tbl.push_back(mk(1, JZ_,   0, 1, 0, 0, BN, A_AND));
    tbl.push_back(mk(1, JC_,   1, 0, 0, 0, BT, A_AND));
    tbl.push_back(mk(1, JC_,   0, 0, 0, 0, BN, A_AND));
    tbl.push_back(mk(1, XOR_,  0, 0, 0, 0, WE, A_XOR));
    tbl.push_back(mk(1, XOR_,  0, 0, 1, 1, WE, A_XOR));
    tbl.push_back(mk(1, XOR_,  0, 0, 0, 2, WE, A_XOR));
    tbl.push_back(mk(1, HLT_,  0, 0, 0, 3, WE|LST, A_XOR));
    tbl.push_back(mk(1, HLT_,  0, 0, 0, 0, ST, A_AND));
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1)
        tbl.push_back(mk(1, JMP_, 1, 1, 0, 0, ST, A_AND));
      else
        tbl.push_back(mk(1, SUB_, 0, 0, 0, 0, ST, A_SUB));
    end
    tbl.push_back(mk(1, SUB_, 0, 0, 1, 0, WE, A_SUB));
    tbl.push_back(mk(1, SUB_, 0, 0, 0, 1, CC|WE, A_SUB));
    tbl.push_back(mk(1, SUB_, 0, 0, 0, 2, CC|WE, A_SUB));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i), 1'b0, none);

    // Reset lands mid-way through limb 2 of SUB, between edges.
    reset_n = 1'b0;
    q0.push_back(ox(0, IN, A_SUB));
    #1;
    e = q0.pop_front();
    cmp("async_reset", act0(), e);
    ir_last  = ir_enable;
    ir1_last = w1_ir_enable;

    // WORDS=1 instance runs alongside from here.
    apply(mk(0, ADD_, 0, 0, 0, 0, IN, A_ADD), "r0", 1'b1,
          ox(0, IN, A_ADD));
    apply(mk(1, ADD_, 0, 0, 0, 0, WE, A_ADD), "r1", 1'b1,
          ox(0, WE|LST, A_ADD));
    apply(mk(1, ADD_, 0, 0, 0, 1, CC|WE, A_ADD), "r2", 1'b1,
          ox(0, WE|LST, A_ADD));
    apply(mk(1, JMP_, 0, 0, 0, 2, CC|WE, A_ADD), "r3", 1'b1,
          ox(0, BT, A_AND));
    apply(mk(1, ADD_, 0, 0, 0, 3, CC|WE|LST, A_ADD), "r4", 1'b1,
          ox(0, WE|LST, A_ADD));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
